// File: rtl/uart_pkg.sv
// Shared UART definitions: baud constants, rate-select and FSM encodings, tick divisor.
package uart_pkg;

  localparam int unsigned BAUD_2400  = 2400;
  localparam int unsigned BAUD_4800  = 4800;
  localparam int unsigned BAUD_9600  = 9600;
  localparam int unsigned BAUD_19200 = 19200;

  typedef enum logic [1:0] {
    BR_2400  = 2'b00,
    BR_4800  = 2'b01,
    BR_9600  = 2'b10,
    BR_19200 = 2'b11
  } baud_sel_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // Clocks per oversample tick, truncated toward zero.
  function automatic logic [15:0] baud_div(input int unsigned freq,
                                           input int unsigned baud,
                                           input int unsigned oversample);
    return 16'(freq / (baud * oversample));
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// Oversample tick generator: divisor selected by baud_sel, counter held at zero by clear.
module uart_rx_tick
  import uart_pkg::*;
#(
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic [1:0] baud_sel,
  input  logic       clear,
  output logic       tick
);

  localparam logic [15:0] DIV_2400  = baud_div(FREQ, BAUD_2400,  OVERSAMPLE);
  localparam logic [15:0] DIV_4800  = baud_div(FREQ, BAUD_4800,  OVERSAMPLE);
  localparam logic [15:0] DIV_9600  = baud_div(FREQ, BAUD_9600,  OVERSAMPLE);
  localparam logic [15:0] DIV_19200 = baud_div(FREQ, BAUD_19200, OVERSAMPLE);

  logic [15:0] div;
  logic [15:0] cnt;
  logic        wrap;

  always_comb begin
    div = DIV_19200;
    case (baud_sel)
      BR_2400:  div = DIV_2400;
      BR_4800:  div = DIV_4800;
      BR_9600:  div = DIV_9600;
      default:  div = DIV_19200;
    endcase
  end

  assign wrap = (cnt == div - 16'd1);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clear || wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Held off while cleared so the first tick lands a full divisor after the start edge.
  assign tick = !clear && wrap;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver with 16x oversampling, mid-bit sampling and framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ       = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [1:0]           baud_rate,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  rx_state_e            state;
  logic                 rx_m;
  logic                 rx_s;
  logic [1:0]           baud_lat;
  logic [SW-1:0]        sample_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 tick;
  logic                 bit_tick;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_rx_tick #(
    .FREQ       (FREQ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk      (clk),
    .arst_n   (arst_n),
    .baud_sel (baud_lat),
    .clear    (state == IDLE),
    .tick     (tick)
  );

  assign bit_tick = tick && (sample_cnt == SMP_LAST);
  assign busy     = (state != IDLE);

  // Datapath registers carry no reset; they are only read after being fully loaded.
  always_ff @(posedge clk) begin
    if (state == DATA && bit_tick) begin
      shift <= {rx_s, shift[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (state == PARITY && bit_tick) begin
      par_bit <= rx_s;
    end
  end
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= IDLE;
      sample_cnt   <= '0;
      bit_cnt      <= '0;
      baud_lat     <= BR_2400;
      data_out     <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
    end else begin
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            baud_lat   <= baud_rate;
          end
        end
        START: begin
          if (tick) begin
            if (sample_cnt == SMP_MID) begin
              sample_cnt <= '0;
              state      <= rx_s ? IDLE : DATA;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (bit_tick) begin
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (bit_tick) begin
              state <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            sample_cnt <= sample_cnt + 1'b1;
            if (bit_tick) begin
              if (rx_s) begin
                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (^{shift, par_bit}) begin
                  parity_error <= 1'b1;
                end else begin
                  data_out   <= shift;
                  data_valid <= 1'b1;
                end
`else
                data_out   <= shift;
                data_valid <= 1'b1;
`endif
              end else begin
                frame_error <= 1'b1;
                state       <= BREAK;
              end
            end
          end
        end
        // A line held low after a bad stop bit must not look like a new start bit.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue checked every cycle by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned FREQ = 5_000_000;
  localparam int unsigned OS   = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [1:0] baud_rate = 2'b10;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic       perr;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   vcnt = 0;
  int   fcnt = 0;
  int   pcnt = 0;
  logic [7:0] last_good = 8'h00;
  logic prev_busy = 1'b0;
  ev_t  exp_q[$];

`ifdef UART_RX_PARITY_EN
  logic parity_error;
  assign perr = parity_error;
`else
  assign perr = 1'b0;
`endif

  uart_rx #(
    .FREQ       (FREQ),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .baud_rate    (baud_rate),
    .rx           (rx),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int div_of(input int sel);
    int rates[4];
    rates = '{2400, 4800, 9600, 19200};
    return FREQ / (rates[sel] * OS);
  endfunction

  function automatic logic [2:0] kind_bits(input int kind);
    if (kind == K_VALID) return 3'b100;
    if (kind == K_FERR)  return 3'b010;
    return 3'b001;
  endfunction

  // Model: outcome and cycle of the receiver's decision, from frame contents alone.
  task automatic send_frame(input logic [7:0] b, input int sel, input int bit_clk,
                            input int stop_clk, input logic stop_val, input logic par_val);
    ev_t ev;
    ev.data = b;
    ev.cyc  = cyc + 3 + (8 + OS * (9 + PAR)) * div_of(sel);
    if (!stop_val) ev.kind = K_FERR;
    else if (PAR != 0 && ((^b) ^ par_val)) ev.kind = K_PERR;
    else ev.kind = K_VALID;
    exp_q.push_back(ev);
    rx = 1'b0;
    wait_cyc(bit_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(bit_clk);
    end
    if (PAR != 0) begin
      rx = par_val;
      wait_cyc(bit_clk);
    end
    rx = stop_val;
    wait_cyc(stop_clk);
  endtask

  always @(negedge clk) begin
    ev_t ev;
    if (!arst_n) begin
      last_good = 8'h00;
      chk("reset_outputs", 32'({data_out, data_valid, frame_error, perr, busy}), 32'd0);
    end else begin
      if (data_valid || frame_error || perr) begin
        if (data_valid)  vcnt++;
        if (frame_error) fcnt++;
        if (perr)        pcnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", 32'({data_valid, frame_error, perr}), 32'd0);
        end else begin
          ev = exp_q.pop_front();
          chk("pulse_kind", 32'({data_valid, frame_error, perr}), 32'(kind_bits(ev.kind)));
          chk("pulse_cycle_in_window", 32'(cyc >= ev.cyc - 2 && cyc <= ev.cyc + 2), 32'd1);
          if (data_valid) begin
            last_good = ev.data;
            chk("busy_falls_with_valid", 32'({prev_busy, busy}), 32'b10);
          end
        end
      end
      chk("data_out", 32'(data_out), 32'(last_good));
    end
    prev_busy = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bit96;
    int bit192;
    int v0;
    int f0;
    int p0;
    logic [7:0] b5a;
    bit96  = OS * div_of(2);
    bit192 = FREQ / 19200;

    wait_cyc(5);
    chk("rst_data_out", 32'(data_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    arst_n = 1'b1;
    wait_cyc(20);

    // Good byte; baud_rate is disturbed mid-frame and must not matter.
    v0 = vcnt; f0 = fcnt;
    fork
      send_frame(8'hA5, 2, bit96, bit96, 1'b1, ^8'hA5);
      begin
        wait_cyc(3 * bit96);
        baud_rate = 2'b00;
      end
    join
    wait_cyc(bit96);
    baud_rate = 2'b10;
    chk("a5_data", 32'(data_out), 32'hA5);
    chk("a5_valid_count", 32'(vcnt - v0), 32'd1);
    chk("a5_ferr_count", 32'(fcnt - f0), 32'd0);
    chk("a5_pending", 32'(exp_q.size()), 32'd0);

    // Back-to-back at 19200.
    baud_rate = 2'b11;
    v0 = vcnt;
    send_frame(8'h00, 3, bit192, bit192, 1'b1, 1'b0);
    send_frame(8'hFF, 3, bit192, bit192, 1'b1, 1'b0);
    wait_cyc(bit192);
    chk("b2b_valid_count", 32'(vcnt - v0), 32'd2);
    chk("b2b_data", 32'(data_out), 32'hFF);
    chk("b2b_pending", 32'(exp_q.size()), 32'd0);

    // Glitch shorter than half a bit.
    baud_rate = 2'b10;
    v0 = vcnt; f0 = fcnt;
    rx = 1'b0;
    wait_cyc(100);
    chk("glitch_busy_during", 32'(busy), 32'd1);
    wait_cyc(100);
    rx = 1'b1;
    wait_cyc(600);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_no_valid", 32'(vcnt - v0), 32'd0);
    chk("glitch_no_ferr", 32'(fcnt - f0), 32'd0);

    // Framing error with a long low stop bit.
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 2, bit96, 2000, 1'b0, ^8'h3C);
    chk("ferr_break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_cyc(10);
    chk("ferr_idle_after_high", 32'(busy), 32'd0);
    chk("ferr_count", 32'(fcnt - f0), 32'd1);
    chk("ferr_no_valid", 32'(vcnt - v0), 32'd0);
    chk("ferr_data_kept", 32'(data_out), 32'hFF);
    chk("ferr_pending", 32'(exp_q.size()), 32'd0);

    // Reset during bit 4 of 0x5A, then a clean 0x81.
    b5a = 8'h5A;
    v0 = vcnt;
    rx = 1'b0;
    wait_cyc(bit96);
    for (int i = 0; i < 4; i++) begin
      rx = b5a[i];
      wait_cyc(bit96);
    end
    rx = b5a[4];
    wait_cyc(bit96 / 2);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    arst_n = 1'b0;
    wait_cyc(5);
    chk("mid_reset_data", 32'(data_out), 32'h00);
    chk("mid_reset_busy", 32'(busy), 32'd0);
    arst_n = 1'b1;
    rx = 1'b1;
    wait_cyc(600);
    chk("post_reset_idle", 32'(busy), 32'd0);
    send_frame(8'h81, 2, bit96, bit96, 1'b1, ^8'h81);
    wait_cyc(bit96);
    chk("r81_data", 32'(data_out), 32'h81);
    chk("r81_valid_count", 32'(vcnt - v0), 32'd1);
    chk("r81_pending", 32'(exp_q.size()), 32'd0);

`ifdef UART_RX_PARITY_EN
    v0 = vcnt; p0 = pcnt;
    send_frame(8'h07, 2, bit96, bit96, 1'b1, 1'b1);
    wait_cyc(bit96);
    chk("par_good_data", 32'(data_out), 32'h07);
    chk("par_good_valid", 32'(vcnt - v0), 32'd1);
    send_frame(8'h07, 2, bit96, bit96, 1'b1, 1'b0);
    wait_cyc(bit96);
    chk("par_bad_perr", 32'(pcnt - p0), 32'd1);
    chk("par_bad_no_valid", 32'(vcnt - v0), 32'd1);
    chk("par_bad_data_kept", 32'(data_out), 32'h07);
`else
    p0 = pcnt;
    chk("no_parity_pulses", 32'(pcnt - p0), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
